// File: rtl/systolic_pkg.sv
// Shared types and sizes for the systolic stream controller.
// SYSTOLIC_CHECKSUM_EN adds a fifth (checksum) result byte.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam int IMG_BYTES = 16;
  localparam int FLT_BYTES = 9;
  localparam int OPS_BYTES = IMG_BYTES + FLT_BYTES;

`ifdef SYSTOLIC_CHECKSUM_EN
  localparam int RES_BYTES = 5;
`else
  localparam int RES_BYTES = 4;
`endif

endpackage

// File: rtl/systolic_result_serializer.sv
// Captures the 2x2 array result and streams it out byte by byte.
// SYSTOLIC_CHECKSUM_EN appends the modular sum of the four bytes.
module systolic_result_serializer
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] o00,
  input  logic [DATA_W-1:0] o01,
  input  logic [DATA_W-1:0] o10,
  input  logic [DATA_W-1:0] o11,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam logic [2:0] LAST_RIDX = 3'(RES_BYTES - 1);

  logic [DATA_W-1:0] res_q [RES_BYTES];
  logic [DATA_W-1:0] res_d [RES_BYTES];
  logic [2:0]        ridx_q, ridx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Capture, then advance one result byte per output handshake.
  always_comb begin
    res_d   = res_q;
    ridx_d  = ridx_q;
    valid_d = valid_q;
    data_d  = data_q;
    done    = 1'b0;
    if (capture) begin
      res_d[0] = o00;
      res_d[1] = o01;
      res_d[2] = o10;
      res_d[3] = o11;
`ifdef SYSTOLIC_CHECKSUM_EN
      res_d[4] = o00 + o01 + o10 + o11;
`endif
      ridx_d  = '0;
      valid_d = 1'b1;
      data_d  = o00;
    end else if (valid_q && out_ready) begin
      if (ridx_q == LAST_RIDX) begin
        done    = 1'b1;
        valid_d = 1'b0;
        ridx_d  = '0;
      end else begin
        ridx_d = ridx_q + 3'd1;
        data_d = res_q[ridx_d];
      end
    end
  end

  // Result and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '{default: '0};
      ridx_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      res_q   <= res_d;
      ridx_q  <= ridx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Byte-stream loader / result drainer for two_by_two_systolic.
// SYSTOLIC_CHECKSUM_EN (in the serializer) adds a checksum byte.
module systolic_stream_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int COMPUTE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              arr_rst,
  output logic [DATA_W-1:0] i00, i01, i02, i03,
  output logic [DATA_W-1:0] i10, i11, i12, i13,
  output logic [DATA_W-1:0] i20, i21, i22, i23,
  output logic [DATA_W-1:0] i30, i31, i32, i33,
  output logic [DATA_W-1:0] f00, f01, f02,
  output logic [DATA_W-1:0] f10, f11, f12,
  output logic [DATA_W-1:0] f20, f21, f22,
  input  logic [DATA_W-1:0] o00,
  input  logic [DATA_W-1:0] o01,
  input  logic [DATA_W-1:0] o10,
  input  logic [DATA_W-1:0] o11
);

  localparam logic [4:0] LAST_IDX = 5'(OPS_BYTES - 1);
  localparam logic [7:0] LAST_CNT = 8'(COMPUTE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              arr_rst_q, arr_rst_d;
  logic [DATA_W-1:0] ops_q [OPS_BYTES];
  logic [DATA_W-1:0] ops_d [OPS_BYTES];
  logic              capture;
  logic              done;

  // Next-state, operand load and run counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    capture = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          ops_d[idx_q] = in_data;
          if (idx_q == LAST_IDX) state_d = ST_START;
          else idx_d = idx_q + 5'd1;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    in_ready_d = (state_d == ST_LOAD);
    arr_rst_d  = (state_d != ST_RUN);
  end

  // State, index, counter and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      arr_rst_q  <= 1'b1;
      ops_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      arr_rst_q  <= arr_rst_d;
      ops_q      <= ops_d;
    end
  end

  systolic_result_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .o00      (o00),
    .o01      (o01),
    .o10      (o10),
    .o11      (o11),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .done     (done)
  );

  assign in_ready = in_ready_q;
  assign arr_rst  = arr_rst_q;

  assign i00 = ops_q[0];
  assign i01 = ops_q[1];
  assign i02 = ops_q[2];
  assign i03 = ops_q[3];
  assign i10 = ops_q[4];
  assign i11 = ops_q[5];
  assign i12 = ops_q[6];
  assign i13 = ops_q[7];
  assign i20 = ops_q[8];
  assign i21 = ops_q[9];
  assign i22 = ops_q[10];
  assign i23 = ops_q[11];
  assign i30 = ops_q[12];
  assign i31 = ops_q[13];
  assign i32 = ops_q[14];
  assign i33 = ops_q[15];
  assign f00 = ops_q[16];
  assign f01 = ops_q[17];
  assign f02 = ops_q[18];
  assign f10 = ops_q[19];
  assign f11 = ops_q[20];
  assign f12 = ops_q[21];
  assign f20 = ops_q[22];
  assign f21 = ops_q[23];
  assign f22 = ops_q[24];

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Directed bench for systolic_stream_ctrl with a behavioural 2x2 array.
// Define SYSTOLIC_CHECKSUM_EN to expect the checksum byte as well.
module tb_systolic_stream_ctrl;

`ifdef SYSTOLIC_CHECKSUM_EN
  localparam int NRES = 5;
`else
  localparam int NRES = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, arr_rst;
  logic [7:0] out_data;
  logic [7:0] i00, i01, i02, i03, i10, i11, i12, i13;
  logic [7:0] i20, i21, i22, i23, i30, i31, i32, i33;
  logic [7:0] f00, f01, f02, f10, f11, f12, f20, f21, f22;
  logic [7:0] a_o [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  int frame [25] = '{8, 3, 9, 1, 7, 7, 2, 8, 5, 6, 3, 1, 4, 9, 2, 6,
                     1, 5, 8, 6, 0, 7, 3, 1, 2};
  int exp_res [5] = '{178, 177, 134, 165, 142};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_stream_ctrl #(.DATA_W(8), .COMPUTE_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .arr_rst(arr_rst),
    .i00(i00), .i01(i01), .i02(i02), .i03(i03),
    .i10(i10), .i11(i11), .i12(i12), .i13(i13),
    .i20(i20), .i21(i21), .i22(i22), .i23(i23),
    .i30(i30), .i31(i31), .i32(i32), .i33(i33),
    .f00(f00), .f01(f01), .f02(f02),
    .f10(f10), .f11(f11), .f12(f12),
    .f20(f20), .f21(f21), .f22(f22),
    .o00(a_o[0]), .o01(a_o[1]), .o10(a_o[2]), .o11(a_o[3])
  );

  logic [7:0] im [16];
  logic [7:0] fl [9];
  assign im = '{i00, i01, i02, i03, i10, i11, i12, i13,
                i20, i21, i22, i23, i30, i31, i32, i33};
  assign fl = '{f00, f01, f02, f10, f11, f12, f20, f21, f22};

  function automatic logic [7:0] conv(int r, int c);
    int s = 0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        s += int'(im[(r + a) * 4 + c + b]) * int'(fl[a * 3 + b]);
    return 8'(s);
  endfunction

  // Stand-in array: valid 3x3 convolution, held at zero in reset.
  always @(posedge clk) begin
    if (arr_rst) a_o <= '{default: '0};
    else a_o <= '{conv(0, 0), conv(0, 1), conv(1, 0), conv(1, 1)};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic load_frame(input bit gapped, input int nbytes);
    int t;
    for (int k = 0; k < nbytes; k++) begin
      if (gapped) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(frame[k]);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("in_ready_wait", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int low_cnt, output int lat);
    low_cnt = 0;
    lat = -1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = cyc - last_acc;
        break;
      end
      if (!arr_rst) low_cnt++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 1);
  endtask

  task automatic drain(input int nbytes);
    int t;
    @(negedge clk);
    out_ready = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("drain_valid", {31'd0, out_valid}, 1);
      chk("drain_data", {24'd0, out_data}, exp_res[b]);
      chk("drain_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_data"}, {24'd0, out_data}, 0);
    chk({tag, "_arr_rst"}, {31'd0, arr_rst}, 1);
    chk({tag, "_i00"}, {24'd0, i00}, 0);
    chk({tag, "_f22"}, {24'd0, f22}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, lat;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    chk("in_ready_pre_edge", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    chk("in_ready_rise", {31'd0, in_ready}, 1);

    // Frame 1: results plus arr_rst / latency timing.
    load_frame(1'b0, 25);
    chk("in_ready_after_last", {31'd0, in_ready}, 0);
    chk("arr_rst_after_last", {31'd0, arr_rst}, 1);
    wait_result(low, lat);
    chk("arr_rst_low_cycles", low, 16);
    chk("out_valid_latency", lat, 17);
    drain(NRES);
    chk("in_ready_back", {31'd0, in_ready}, 1);
    chk("out_valid_done", {31'd0, out_valid}, 0);

    // Frame 2 (back to back): stall DRAIN for 10 cycles.
    load_frame(1'b0, 25);
    wait_result(low, lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {31'd0, out_valid}, 1);
      chk("stall_data", {24'd0, out_data}, 178);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
    end
    drain(NRES);
    chk("in_ready_back2", {31'd0, in_ready}, 1);

    // Frame 3: gapped load, noise on in_valid during RUN.
    frame[0] = 9;
    exp_res[0] = 179;
    exp_res[4] = 143;
    load_frame(1'b1, 25);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      in_data  = 8'hFF;
    end
    in_valid = 1'b0;
    chk("op_i00", {24'd0, i00}, 9);
    chk("op_i12", {24'd0, i12}, 2);
    chk("op_i33", {24'd0, i33}, 6);
    chk("op_f00", {24'd0, f00}, 1);
    chk("op_f11", {24'd0, f11}, 0);
    chk("op_f22", {24'd0, f22}, 2);
    wait_result(low, lat);
    chk("op_f22_after_run", {24'd0, f22}, 2);
    drain(NRES);
    frame[0] = 8;
    exp_res[0] = 178;
    exp_res[4] = 142;

    // Reset mid-load after 12 bytes.
    load_frame(1'b0, 12);
    chk("mid_load_i00", {24'd0, i00}, 8);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("rst_load");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-drain after 3 bytes.
    load_frame(1'b0, 25);
    wait_result(low, lat);
    drain(3);
    chk("mid_drain_valid", {31'd0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("rst_drain");
    @(negedge clk);
    rst = 1'b0;

    // Fresh frame after reset.
    load_frame(1'b0, 25);
    wait_result(low, lat);
    chk("fresh_latency", lat, 17);
    drain(NRES);
    chk("in_ready_final", {31'd0, in_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
